// File: rtl/mem_pkg.sv
// Shared widths, copy-engine state encoding and the overlap-direction test.
package mem_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } copy_state_e;

    // Backward copy is needed when the destination starts inside the source run
    // (modular distance dst - src in [1, len-1]); len == 0 never qualifies.
    function automatic logic is_bwd(input logic [ADDR_W-1:0] src,
                                    input logic [ADDR_W-1:0] dst,
                                    input logic [ADDR_W-1:0] len);
        logic [ADDR_W-1:0] diff;
        diff = dst - src;
        return (diff != '0) && (diff < len);
    endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Memmove-style byte copy engine: one read cycle and one write cycle per byte,
// walking backward when the destination overlaps the tail of the source.
module mem_copy_engine
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
);

    copy_state_e       state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] dreg_q, dreg_d;
    logic              bwd_q, bwd_d;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] last_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            dreg_q  <= '0;
            bwd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            dreg_q  <= dreg_d;
            bwd_q   <= bwd_d;
        end
    end

    assign last_cnt = len_q - ADDR_W'(1);
    assign off      = bwd_q ? (last_cnt - cnt_q) : cnt_q;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        dreg_d    = dreg_q;
        bwd_d     = bwd_q;
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    cnt_d   = '0;
                    bwd_d   = is_bwd(src, dst, len);
                    state_d = (len != '0) ? RD : FIN;
                end
            end
            RD: begin
                mem_addr  = src_q + off;
                mem_rd_en = 1'b1;
                busy      = 1'b1;
                dreg_d    = mem_rdata;
                state_d   = WR;
            end
            WR: begin
                mem_addr  = dst_q + off;
                mem_wr_en = 1'b1;
                mem_wdata = dreg_q;
                busy      = 1'b1;
                cnt_d     = cnt_q + ADDR_W'(1);
                state_d   = (cnt_q == last_cnt) ? FIN : RD;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
